// File: rtl/alu_step_sequencer_if.sv
// Request/status and datapath-enable bundle between a controller and the ALU step sequencer.
// The slave side is the sequencer; the master side issues requests and observes enables.
interface alu_step_sequencer_if #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4,
    parameter int OP_W     = 5
);
    logic                start;
    logic [OP_W-1:0]     op_code;
    logic                unary;
    logic                wide;
    logic [IDX_W-1:0]    src_a;
    logic [IDX_W-1:0]    src_b;
    logic [IDX_W-1:0]    dst_lo;
    logic [IDX_W-1:0]    dst_hi;

    logic                busy;
    logic                done;
    logic                err;
    logic [OP_W-1:0]     op;
    logic [NUM_REGS-1:0] Rout;
    logic [NUM_REGS-1:0] Rin;
    logic                Yin;
    logic                Zhighin;
    logic                Zlowin;
    logic                Zlowout;
    logic                Zhighout;

    modport master (
        output start, op_code, unary, wide, src_a, src_b, dst_lo, dst_hi,
        input  busy, done, err, op, Rout, Rin, Yin, Zhighin, Zlowin, Zlowout, Zhighout
    );

    modport slave (
        input  start, op_code, unary, wide, src_a, src_b, dst_lo, dst_hi,
        output busy, done, err, op, Rout, Rin, Yin, Zhighin, Zlowin, Zlowout, Zhighout
    );
endinterface

// File: rtl/alu_step_sequencer.sv
// Sequences one register-to-register ALU operation as a fixed series of bus transfer steps,
// with Moore-decoded one-hot register enables and a one-cycle done/err completion pulse.
module alu_step_sequencer #(
    parameter int NUM_REGS = 16,
    parameter int IDX_W    = 4,
    parameter int OP_W     = 5
) (
    input  logic                Clock,
    input  logic                clear,
    alu_step_sequencer_if.slave bus,
    output logic [2:0]          state_o
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        T_A  = 3'd1,
        T_B  = 3'd2,
        T_LO = 3'd3,
        T_HI = 3'd4,
        DONE = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              unary_q, unary_d;
    logic              wide_q, wide_d;
    logic [IDX_W-1:0]  src_a_q, src_a_d;
    logic [IDX_W-1:0]  src_b_q, src_b_d;
    logic [IDX_W-1:0]  dst_lo_q, dst_lo_d;
    logic [IDX_W-1:0]  dst_hi_q, dst_hi_d;

    logic              err_flag;
    logic [NUM_REGS-1:0] rout, rin;

    function automatic logic in_range(input logic [IDX_W-1:0] idx);
        return int'(idx) < NUM_REGS;
    endfunction

    // Out-of-range indices decode to an all-zero vector, suppressing the enable.
    function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            v[i] = (int'(idx) == i);
        end
        return v;
    endfunction

    always_ff @(posedge Clock or posedge clear) begin
        if (clear) begin
            state_q  <= IDLE;
            op_q     <= '0;
            unary_q  <= 1'b0;
            wide_q   <= 1'b0;
            src_a_q  <= '0;
            src_b_q  <= '0;
            dst_lo_q <= '0;
            dst_hi_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            unary_q  <= unary_d;
            wide_q   <= wide_d;
            src_a_q  <= src_a_d;
            src_b_q  <= src_b_d;
            dst_lo_q <= dst_lo_d;
            dst_hi_q <= dst_hi_d;
        end
    end

    // start is a level request sampled only in IDLE; while busy it is dropped, never queued.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        unary_d  = unary_q;
        wide_d   = wide_q;
        src_a_d  = src_a_q;
        src_b_d  = src_b_q;
        dst_lo_d = dst_lo_q;
        dst_hi_d = dst_hi_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    op_d     = bus.op_code;
                    unary_d  = bus.unary;
                    wide_d   = bus.wide;
                    src_a_d  = bus.src_a;
                    src_b_d  = bus.src_b;
                    dst_lo_d = bus.dst_lo;
                    dst_hi_d = bus.dst_hi;
                    state_d  = bus.unary ? T_B : T_A;
                end
            end
            T_A:     state_d = T_B;
            T_B:     state_d = T_LO;
            T_LO:    state_d = wide_q ? T_HI : DONE;
            T_HI:    state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Only indices the sequence actually drives count toward err.
    assign err_flag = (!unary_q && !in_range(src_a_q)) ||
                      !in_range(src_b_q) ||
                      !in_range(dst_lo_q) ||
                      (wide_q && !in_range(dst_hi_q));

    always_comb begin
        bus.busy     = 1'b0;
        bus.done     = 1'b0;
        bus.err      = 1'b0;
        bus.op       = '0;
        bus.Yin      = 1'b0;
        bus.Zhighin  = 1'b0;
        bus.Zlowin   = 1'b0;
        bus.Zlowout  = 1'b0;
        bus.Zhighout = 1'b0;
        rout         = '0;
        rin          = '0;
        case (state_q)
            T_A: begin
                bus.busy = 1'b1;
                rout     = onehot(src_a_q);
                bus.Yin  = 1'b1;
            end
            T_B: begin
                bus.busy    = 1'b1;
                rout        = onehot(src_b_q);
                bus.Zlowin  = 1'b1;
                bus.Zhighin = 1'b1;
                bus.op      = op_q;
            end
            T_LO: begin
                bus.busy    = 1'b1;
                bus.Zlowout = 1'b1;
                rin         = onehot(dst_lo_q);
            end
            T_HI: begin
                bus.busy     = 1'b1;
                bus.Zhighout = 1'b1;
                rin          = onehot(dst_hi_q);
            end
            DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                bus.err  = err_flag;
            end
            default: ;
        endcase
    end

    assign bus.Rout = rout;
    assign bus.Rin  = rin;
    assign state_o  = state_q;

endmodule

// File: doc/alu_step_sequencer.md
ALU_STEP_SEQUENCER -- requirements
Module: alu_step_sequencer

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- NUM_REGS, 16, general registers driven by the one-hot enables
- IDX_W, 4, register index width; 2**IDX_W >= NUM_REGS
- OP_W, 5, ALU op-code width
REQ-002 Ports (name, direction, width, meaning) SHALL be:
- Clock, in, 1, single clock; all state changes on the rising edge
- clear, in, 1, asynchronous active-high reset
- start, in, 1, request a register-to-register ALU operation
- op_code, in, OP_W, ALU operation for the request
- unary, in, 1, 1 = single-operand op (no Y load)
- wide, in, 1, 1 = also write Z high to dst_hi
- src_a, in, IDX_W, operand A register (loaded into Y)
- src_b, in, IDX_W, operand B register (driven during execute)
- dst_lo, in, IDX_W, destination for Z low
- dst_hi, in, IDX_W, destination for Z high
- busy, out, 1, operation in progress
- done, out, 1, one-cycle completion pulse
- err, out, 1, one-cycle pulse with done if any index >= NUM_REGS
- op, out, OP_W, op code presented to the ALU
- Rout, out, NUM_REGS, one-hot register-to-bus enables
- Rin, out, NUM_REGS, one-hot bus-to-register enables
- Yin, Zhighin, Zlowin, Zlowout, Zhighout, out, 1 each, datapath transfer enables

Function
REQ-003 States SHALL be IDLE, T_A, T_B, T_LO, T_HI, DONE, held in a registered state variable.
REQ-004 In IDLE with start=1 at a rising edge, the block SHALL latch op_code, unary, wide, src_a, src_b, dst_lo, dst_hi and go to T_A (unary=0) or T_B (unary=1).
REQ-005 Transitions SHALL be T_A->T_B, T_B->T_LO, T_LO->T_HI (wide=1) or DONE (wide=0), T_HI->DONE, DONE->IDLE, each after exactly one cycle.
REQ-006 Outputs SHALL be Moore-decoded from the state and latched fields only:
- T_A: Rout[src_a]=1, Yin=1
- T_B: Rout[src_b]=1, Zlowin=1, Zhighin=1, op=latched op_code
- T_LO: Zlowout=1, Rin[dst_lo]=1
- T_HI: Zhighout=1, Rin[dst_hi]=1
- DONE: done=1; err=1 if any used index >= NUM_REGS
- all other enables 0; op=0 outside T_B
REQ-007 At most one Rout bit and one Rin bit SHALL be high in any cycle; Rout and Rin SHALL never be high in the same cycle.
REQ-008 An out-of-range index SHALL suppress its Rout/Rin bit (no bit set) while the sequence still runs to completion.
REQ-009 busy SHALL be 1 in every state except IDLE; start while busy SHALL be ignored with no queuing.
REQ-010 Latency from the accepting edge to done=1 SHALL be 4 cycles for binary/narrow, 5 for binary/wide, 3 for unary/narrow, and 4 for unary/wide.
REQ-011 start=1 during DONE SHALL be ignored; the earliest next accept is the first IDLE cycle, which gives one idle cycle between operations.
REQ-012 If dst_lo == dst_hi with wide=1, both writes SHALL occur in order (low, then high) and no error SHALL be flagged.
REQ-013 Input changes after acceptance SHALL NOT affect the running sequence.

Reset
REQ-014 With clear=1 the state SHALL go to IDLE immediately, regardless of Clock, with busy, done, err, op, Rout, Rin and all transfer enables at 0, and latched fields at 0.
REQ-015 Asserting clear mid-operation SHALL abort the operation with no further enables; the first accept is possible on the first rising edge after clear deasserts.

Verification
REQ-016 Bench SHALL cover:
- binary/narrow op_code=5'b00110, src_a=3, src_b=2, dst_lo=1 -> Rout=0x0008+Yin; Rout=0x0004+Zlowin/Zhighin with op=6; Zlowout+Rin=0x0002; done in cycle 4
- unary/wide, src_b=2, dst_lo=1, dst_hi=0 -> no Yin cycle; T_B, T_LO (Rin=0x0002), T_HI (Zhighout, Rin=0x0001); done in cycle 4
- start pulsed every cycle across two operations -> second accepted only in IDLE, exactly one done per operation, no overlap of enables
- dst_lo=dst_hi=5, wide=1 -> Rin=0x0020 in two consecutive cycles; err=0
- NUM_REGS=8, src_b=9 -> Rout=0 in T_B, err=1 with done
- clear asserted in T_B -> all outputs 0 asynchronously, state IDLE; next start completes normally
